id_ex_stage: RTL and testbench

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_stage.sv | 177 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection,
// bubble insertion and a saturating count of inserted bubbles.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall_i            global memory stall, freezes all state
//   flush_i            taken branch/jump in EX, squashes the ID instruction
//   id_*               decoded ID-stage instruction fields and datapath values
//   ex_*               registered EX-stage copies of the ID fields
//   if_id_hold         combinational load-use request to hold IF and IF/ID
//   bubble_cnt         saturating count of load-use bubbles inserted

package id_ex_pkg;

    typedef logic [4:0] rv32i_reg;

    typedef struct packed {
        logic        valid;
        rv32i_reg    rs1;
        rv32i_reg    rs2;
        rv32i_reg    rd;
        logic        is_load;
        logic        regwrite;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [15:0] ctrl;
    } id_ex_t;

    localparam id_ex_t BUBBLE = '0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

endpackage

module id_ex_stage
    import id_ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic        id_is_load,
    input  logic        id_regwrite,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [15:0] id_ctrl,
    output logic        ex_valid,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic        ex_is_load,
    output logic        ex_regwrite,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs1_data,
    output logic [31:0] ex_rs2_data,
    output logic [31:0] ex_imm,
    output logic [15:0] ex_ctrl,
    output logic        if_id_hold,
    output logic [15:0] bubble_cnt
);

    id_ex_t      ex_q;
    id_ex_t      ex_d;
    id_ex_t      capture;
    logic [15:0] bubble_q;
    logic [15:0] bubble_d;

    logic rs1_hit;
    logic rs2_hit;
    logic hazard;

    logic sel_stall;
    logic sel_flush;
    logic sel_bubble;
    logic sel_capture;

    // Load-use: the EX load's result is not ready for an ID reader.
    // x0 as a load destination never creates a dependency.
    always_comb begin
        rs1_hit = id_uses_rs1 & (id_rs1 == ex_q.rd);
        rs2_hit = id_uses_rs2 & (id_rs2 == ex_q.rd);
        hazard  = ex_q.valid
                & ex_q.is_load
                & (ex_q.rd != 5'd0)
                & id_valid
                & (rs1_hit | rs2_hit);
    end

    // A flush squashes the dependent instruction, so no hold is needed.
    assign if_id_hold = hazard & ~flush_i;

    // One-hot edge action, priority stall > flush > hazard > capture.
    always_comb begin
        sel_stall   = stall_i;
        sel_flush   = ~stall_i & flush_i;
        sel_bubble  = ~stall_i & ~flush_i & hazard;
        sel_capture = ~stall_i & ~flush_i & ~hazard;
    end

    // Unused sources are zeroed so they never match in forwarding.
    // An invalid slot must not look like a writer or a load.
    always_comb begin
        capture          = BUBBLE;
        capture.valid    = id_valid;
        capture.rs1      = id_uses_rs1 ? id_rs1 : 5'd0;
        capture.rs2      = id_uses_rs2 ? id_rs2 : 5'd0;
        capture.rd       = id_valid ? id_rd : 5'd0;
        capture.is_load  = id_valid & id_is_load;
        capture.regwrite = id_valid & id_regwrite;
        capture.pc       = id_pc;
        capture.rs1_data = id_rs1_data;
        capture.rs2_data = id_rs2_data;
        capture.imm      = id_imm;
        capture.ctrl     = id_ctrl;
    end

    always_comb begin
        ex_d     = ex_q;
        bubble_d = bubble_q;
        unique case (1'b1)
            sel_stall: begin
                ex_d     = ex_q;
                bubble_d = bubble_q;
            end
            sel_flush: begin
                ex_d = BUBBLE;
            end
            sel_bubble: begin
                ex_d = BUBBLE;
                if (bubble_q != CNT_MAX) begin
                    bubble_d = bubble_q + 16'd1;
                end
            end
            sel_capture: begin
                ex_d = capture;
            end
            default: begin
                ex_d     = ex_q;
                bubble_d = bubble_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q     <= BUBBLE;
            bubble_q <= 16'd0;
        end else begin
            ex_q     <= ex_d;
            bubble_q <= bubble_d;
        end
    end

    assign ex_valid    = ex_q.valid;
    assign ex_rs1      = ex_q.rs1;
    assign ex_rs2      = ex_q.rs2;
    assign ex_rd       = ex_q.rd;
    assign ex_is_load  = ex_q.is_load;
    assign ex_regwrite = ex_q.regwrite;
    assign ex_pc       = ex_q.pc;
    assign ex_rs1_data = ex_q.rs1_data;
    assign ex_rs2_data = ex_q.rs2_data;
    assign ex_imm      = ex_q.imm;
    assign ex_ctrl     = ex_q.ctrl;
    assign bubble_cnt  = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed and randomized checks of id_ex_stage against
// a behavioural model of the ID/EX register and load-use bubble counter.

module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        id_valid;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [4:0]  id_rd;
    logic        id_uses_rs1;
    logic        id_uses_rs2;
    logic        id_is_load;
    logic        id_regwrite;
    logic [31:0] id_pc;
    logic [31:0] id_rs1_data;
    logic [31:0] id_rs2_data;
    logic [31:0] id_imm;
    logic [15:0] id_ctrl;
    logic        ex_valid;
    logic [4:0]  ex_rs1;
    logic [4:0]  ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_is_load;
    logic        ex_regwrite;
    logic [31:0] ex_pc;
    logic [31:0] ex_rs1_data;
    logic [31:0] ex_rs2_data;
    logic [31:0] ex_imm;
    logic [15:0] ex_ctrl;
    logic        if_id_hold;
    logic [15:0] bubble_cnt;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .id_is_load  (id_is_load),
        .id_regwrite (id_regwrite),
        .id_pc       (id_pc),
        .id_rs1_data (id_rs1_data),
        .id_rs2_data (id_rs2_data),
        .id_imm      (id_imm),
        .id_ctrl     (id_ctrl),
        .ex_valid    (ex_valid),
        .ex_rs1      (ex_rs1),
        .ex_rs2      (ex_rs2),
        .ex_rd       (ex_rd),
        .ex_is_load  (ex_is_load),
        .ex_regwrite (ex_regwrite),
        .ex_pc       (ex_pc),
        .ex_rs1_data (ex_rs1_data),
        .ex_rs2_data (ex_rs2_data),
        .ex_imm      (ex_imm),
        .ex_ctrl     (ex_ctrl),
        .if_id_hold  (if_id_hold),
        .bubble_cnt  (bubble_cnt)
    );

    int passed = 0;
    int total  = 0;

    // Model of what EX should hold: the last instruction let through.
    logic        m_valid;
    logic [4:0]  m_rs1;
    logic [4:0]  m_rs2;
    logic [4:0]  m_rd;
    logic        m_load;
    logic        m_rw;
    logic [31:0] m_pc;
    logic [31:0] m_d1;
    logic [31:0] m_d2;
    logic [31:0] m_imm;
    logic [15:0] m_ctrl;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_clear();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0;
        m_load = 0; m_rw = 0; m_pc = 0; m_d1 = 0;
        m_d2 = 0; m_imm = 0; m_ctrl = 0;
    endtask

    // ID needs a register the EX load has not produced yet.
    function automatic logic model_dep();
        logic reads_rd;
        reads_rd = (id_uses_rs1 && id_rs1 == m_rd)
                || (id_uses_rs2 && id_rs2 == m_rd);
        return m_valid && m_load && m_rd != 0 && id_valid && reads_rd;
    endfunction

    task automatic model_edge();
        logic dep;
        dep = model_dep();
        if (!rst_n) begin
            model_clear();
            m_cnt = 0;
        end else if (stall_i) begin
            m_cnt = m_cnt;
        end else if (flush_i) begin
            model_clear();
        end else if (dep) begin
            model_clear();
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else begin
            m_valid = id_valid;
            m_rs1   = id_uses_rs1 ? id_rs1 : 5'd0;
            m_rs2   = id_uses_rs2 ? id_rs2 : 5'd0;
            m_rd    = id_valid ? id_rd : 5'd0;
            m_load  = id_valid && id_is_load;
            m_rw    = id_valid && id_regwrite;
            m_pc    = id_pc;
            m_d1    = id_rs1_data;
            m_d2    = id_rs2_data;
            m_imm   = id_imm;
            m_ctrl  = id_ctrl;
        end
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_valid"}, 32'(ex_valid),    32'(m_valid));
        check({tag, "_rs1"},   32'(ex_rs1),      32'(m_rs1));
        check({tag, "_rs2"},   32'(ex_rs2),      32'(m_rs2));
        check({tag, "_rd"},    32'(ex_rd),       32'(m_rd));
        check({tag, "_load"},  32'(ex_is_load),  32'(m_load));
        check({tag, "_rw"},    32'(ex_regwrite), 32'(m_rw));
        check({tag, "_pc"},    ex_pc,            m_pc);
        check({tag, "_d1"},    ex_rs1_data,      m_d1);
        check({tag, "_d2"},    ex_rs2_data,      m_d2);
        check({tag, "_imm"},   ex_imm,           m_imm);
        check({tag, "_ctrl"},  32'(ex_ctrl),     32'(m_ctrl));
        check({tag, "_cnt"},   32'(bubble_cnt),  32'(m_cnt));
    endtask

    // Hold is checked mid-cycle, then the edge, then the registers.
    task automatic tick(input string tag);
        logic exp_hold;
        #1;
        exp_hold = model_dep() && !flush_i;
        check({tag, "_hold"}, 32'(if_id_hold), 32'(exp_hold));
        model_edge();
        @(posedge clk);
        #1;
        check_regs(tag);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic u1, input logic u2,
                          input logic ld, input logic rw);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_rd       = rd;
        id_uses_rs1 = u1;
        id_uses_rs2 = u2;
        id_is_load  = ld;
        id_regwrite = rw;
        id_pc       = $urandom;
        id_rs1_data = $urandom;
        id_rs2_data = $urandom;
        id_imm      = $urandom;
        id_ctrl     = 16'($urandom);
    endtask

    initial begin
        rst_n   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        set_id(1, 5, 5, 5, 1, 1, 1, 1);
        model_clear();
        m_cnt = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_regs("reset");
        check("reset_hold", 32'(if_id_hold), 32'd0);
        rst_n = 1'b1;

        // lw x5 then dependent add x6,x5,x1
        set_id(1, 2, 0, 5, 1, 0, 1, 1);
        tick("lw5");
        set_id(1, 5, 1, 6, 1, 1, 0, 1);
        #1;
        check("luse_hold_now", 32'(if_id_hold), 32'd1);
        tick("luse_bub");
        check("luse_bub_valid", 32'(ex_valid), 32'd0);
        check("luse_bub_rd", 32'(ex_rd), 32'd0);
        check("luse_bub_cnt", 32'(bubble_cnt), 32'd1);
        tick("luse_add");
        check("luse_add_rs1", 32'(ex_rs1), 32'd5);
        check("luse_add_valid", 32'(ex_valid), 32'd1);

        // lw x0 never blocks a reader of x0
        set_id(1, 1, 0, 0, 1, 0, 1, 1);
        tick("lw0");
        set_id(1, 0, 0, 6, 1, 1, 0, 1);
        tick("x0_add");
        check("x0_add_rd", 32'(ex_rd), 32'd6);
        check("x0_cnt", 32'(bubble_cnt), 32'd1);

        // hazard held under stall for three cycles
        set_id(1, 2, 0, 5, 1, 0, 1, 1);
        tick("st_lw");
        set_id(1, 5, 1, 6, 1, 1, 0, 1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("st_hold", 32'(if_id_hold), 32'd1);
            tick("st_frz");
            check("st_frz_rd", 32'(ex_rd), 32'd5);
            check("st_frz_cnt", 32'(bubble_cnt), 32'd1);
        end
        stall_i = 1'b0;
        tick("st_bub");
        check("st_bub_valid", 32'(ex_valid), 32'd0);
        check("st_bub_cnt", 32'(bubble_cnt), 32'd2);
        tick("st_add");

        // flush beats hazard
        set_id(1, 2, 0, 5, 1, 0, 1, 1);
        tick("fl_lw");
        set_id(1, 1, 5, 6, 1, 1, 0, 1);
        flush_i = 1'b1;
        #1;
        check("fl_hold", 32'(if_id_hold), 32'd0);
        tick("fl_bub");
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_cnt", 32'(bubble_cnt), 32'd2);
        flush_i = 1'b0;

        // lui x7 with a stale rs1 field
        set_id(1, 5, 0, 7, 0, 0, 0, 1);
        tick("lui");
        check("lui_rs1", 32'(ex_rs1), 32'd0);
        check("lui_rd", 32'(ex_rd), 32'd7);

        // randomized traffic over a small register set
        for (int i = 0; i < 400; i++) begin
            set_id(1'($urandom_range(3) != 0),
                   5'($urandom_range(3)), 5'($urandom_range(3)),
                   5'($urandom_range(3)),
                   1'($urandom), 1'($urandom),
                   1'($urandom), 1'($urandom));
            stall_i = ($urandom_range(7) == 0);
            flush_i = ($urandom_range(7) == 0);
            tick("rnd");
        end
        stall_i = 1'b0;
        flush_i = 1'b0;

        // counter saturation from a preloaded value
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        tick("pre");
        dut.bubble_q = 16'hFFFE;
        m_cnt = 16'hFFFE;
        for (int i = 0; i < 2; i++) begin
            set_id(1, 2, 0, 5, 1, 0, 1, 1);
            tick("sat_lw");
            set_id(1, 5, 5, 6, 1, 1, 0, 1);
            tick("sat_bub");
            check("sat_cnt", 32'(bubble_cnt), 32'hFFFF);
        end

        // asynchronous reset mid-cycle while stalled
        set_id(1, 2, 0, 5, 1, 0, 1, 1);
        tick("ar_lw");
        stall_i = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        m_cnt = 0;
        check_regs("arst");
        check("arst_hold", 32'(if_id_hold), 32'd0);
        check("arst_cnt", 32'(bubble_cnt), 32'd0);
        @(negedge clk);
        rst_n   = 1'b1;
        stall_i = 1'b0;
        set_id(1, 3, 0, 9, 1, 0, 0, 1);
        model_edge();
        @(posedge clk);
        #1;
        check_regs("post_rst");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
